if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, word address fetched first after reset.
REQ-002 SHALL have parameter PC_STEP, default 32'd1, PC increment per instruction (PC is word-addressed).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redirect_i  input  1  branch/jump taken; kill all fetched and in-flight work.
REQ-006 redirect_pc_i  input  32  next fetch address when redirect_i=1.
REQ-007 imem_req_o  output  1  instruction-memory request.
REQ-008 imem_addr_o  output  32  request word address.
REQ-009 imem_ack_i  input  1  one-cycle response strobe; may be in the same cycle as the first request cycle.
REQ-010 imem_rdata_i  input  32  instruction word, valid when imem_ack_i=1.
REQ-011 Ins_o  output  32  instruction presented to the IF/ID stage.
REQ-012 PC_o  output  32  address of Ins_o.
REQ-013 valid_o  output  1  Ins_o/PC_o hold a live instruction.
REQ-014 ready_i  input  1  IF/ID stage accepts; transfer = valid_o & ready_i.

Function
REQ-015 SHALL hold a 2-entry in-order buffer of {Ins, PC}; count in 0..2; Ins_o/PC_o = head entry; valid_o = (count!=0), registered.
REQ-016 SHALL implement FSM states FETCH and DRAIN.
REQ-017 FETCH: imem_req_o = (count<2), imem_addr_o = pc register.
REQ-018 Memory protocol: once imem_req_o rises, req and addr SHALL stay stable until the cycle of imem_ack_i inclusive.
REQ-019 FETCH, ack without redirect: push {imem_rdata_i, pc}, pc <= pc + PC_STEP (mod 2^32, wraps silently).
REQ-020 Push and pop in the same cycle: count unchanged, order preserved; zero-wait memory with ready_i=1 SHALL give one instruction per cycle.
REQ-021 Pop with count=2: skid entry becomes head next cycle.
REQ-022 No combinational path from ready_i to imem_req_o or imem_addr_o.
REQ-023 redirect_i=1 SHALL take priority over push/pop: count <= 0 (valid_o=0 next cycle), pc <= redirect_pc_i, and any data acked in that cycle SHALL be discarded.
REQ-024 Redirect while a request is raised and not acked: capture drain_addr <= current imem_addr_o and go to DRAIN.
REQ-025 DRAIN: imem_req_o=1, imem_addr_o=drain_addr until ack; the acked data SHALL be discarded; then return to FETCH. The first new request is on the cycle after that ack.
REQ-026 Redirect in DRAIN: pc <= new redirect_pc_i; stay in DRAIN; the newest redirect wins.
REQ-027 Redirect with no request raised, or acked in the same cycle: stay/go FETCH; request redirect_pc_i next cycle.
REQ-028 imem_ack_i with imem_req_o=0 SHALL be ignored; the bench flags it as a protocol error.
REQ-029 Buffer overflow SHALL be impossible by construction: the request is only raised at count<=1, with at most one outstanding.

Reset
REQ-030 While rst=1: state=FETCH, pc=RESET_PC, count=0, valid_o=0, imem_req_o=0, Ins_o=0, PC_o=0; inputs ignored.
REQ-031 First cycle with rst=0: imem_req_o=1, imem_addr_o=RESET_PC.
REQ-032 rst mid-DRAIN or with a request pending SHALL abandon it; a late ack after reset SHALL be ignored if imem_req_o=0, else treated as response to the current request (bench must not issue late acks across reset).

Verification
REQ-033 Zero-wait memory returning rdata=addr+0x1000, ready_i=1 -> valid_o from cycle 2 after reset; PC_o 0,1,2,3 with Ins_o 0x1000,0x1001,... one per cycle.
REQ-034 ready_i=0 for 5 cycles -> count reaches 2; imem_req_o=0 while full; PC_o holds; on ready_i=1, PCs resume in order, none lost or duplicated.
REQ-035 3-wait-state memory; redirect_i=1, redirect_pc_i=0x40 in wait cycle 1 -> addr held until ack, data dropped, next request addr=0x40, PC_o=0x40 first valid.
REQ-036 Redirect to 0x80 in the same cycle as ack of addr 5 -> addr 5 never appears on PC_o; next request 0x80.
REQ-037 Two redirects (0x10 then 0x20) during one DRAIN -> only 0x20 fetched.
REQ-038 pc=32'hFFFF_FFFF, PC_STEP=1 -> next fetch addr 0; rst asserted mid-stream -> valid_o=0 the following cycle; restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response,
// and the instruction handshake toward the IF/ID stage.
interface if_fetch_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] Ins_o;
    logic [31:0] PC_o;
    logic        valid_o;
    logic        ready_i;

    modport master (
        input  redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, ready_i,
        output imem_req_o, imem_addr_o, Ins_o, PC_o, valid_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, ready_i,
        input  imem_req_o, imem_addr_o, Ins_o, PC_o, valid_o
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word-addressed requests to instruction
// memory, queues responses in a 2-entry in-order buffer and presents the
// head entry to IF/ID. A redirect flushes the buffer; a request that is
// already on the bus when a redirect hits is completed and its data dropped.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input logic        clk,
    input logic        rst,
    if_fetch_if.master bus
);

    typedef enum logic {S_FETCH = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_ins [2];
    logic [31:0] r_bpc [2];
    logic [1:0]  r_count;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_push;
    logic        w_pop;
    logic        w_drain_go;
    logic        w_valid;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & bus.ready_i;

    // Next state and memory request; request depends only on state, count and rst
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_addr      = r_pc;
        w_push      = 1'b0;
        w_drain_go  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req  = (r_count != 2'd2);
                w_addr = r_pc;
                if (w_req && bus.imem_ack_i && !bus.redirect_i) begin
                    w_push = 1'b1;
                end
                // An un-acked request must finish before a new address may go out
                if (bus.redirect_i && w_req && !bus.imem_ack_i) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_go  = 1'b1;
                end
            end
            S_DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
                if (bus.imem_ack_i) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
        if (rst) begin
            w_req       = 1'b0;
            w_push      = 1'b0;
            w_drain_go  = 1'b0;
            w_state_nxt = S_FETCH;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC and the address held while draining a killed request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
        end else begin
            if (bus.redirect_i) begin
                r_pc <= bus.redirect_pc_i;
            end else if (w_push) begin
                r_pc <= r_pc + PC_STEP;
            end
            if (w_drain_go) begin
                r_drain_addr <= r_pc;
            end
        end
    end

    // Two-entry in-order buffer; entry 0 is the head shown to IF/ID
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_ins[0] <= 32'd0;
            r_ins[1] <= 32'd0;
            r_bpc[0] <= 32'd0;
            r_bpc[1] <= 32'd0;
        end else if (bus.redirect_i) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b01: begin
                    r_ins[0] <= r_ins[1];
                    r_bpc[0] <= r_bpc[1];
                    r_count  <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_ins[0] <= bus.imem_rdata_i;
                        r_bpc[0] <= r_pc;
                    end else begin
                        r_ins[1] <= bus.imem_rdata_i;
                        r_bpc[1] <= r_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b11: begin
                    // Push needs count<2 and pop needs count>0, so count is 1 here
                    r_ins[0] <= bus.imem_rdata_i;
                    r_bpc[0] <= r_pc;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = w_addr;
    assign bus.valid_o     = w_valid;
    assign bus.Ins_o       = r_ins[0];
    assign bus.PC_o        = r_bpc[0];

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a memory model with configurable wait states, a driver
// that keeps a queue of the expected instruction stream (contiguous PCs from
// the last reset/redirect target), and a monitor that pops and compares on
// every IF/ID transfer and checks the memory-side protocol rules.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd1;
    localparam logic [31:0] INS_OFS  = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;

    if_fetch_if bus();

    if_fetch #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_xfer = 0;

    logic        last_rst = 1'b1;
    logic        last_red = 1'b0;
    logic [31:0] last_rpc = 32'd0;
    logic [31:0] gen_pc   = RESET_PC;
    int          mem_wait  = 0;
    int          mem_cnt   = 0;
    bit          rand_wait = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance to the next falling edge and refresh the expected stream
    task automatic sync_edge();
        exp_t e;
        @(negedge clk);
        if (last_rst || last_red) begin
            exp_q.delete();
            gen_pc = last_rst ? RESET_PC : last_rpc;
        end
        while (exp_q.size() < 8) begin
            e.pc  = gen_pc;
            e.ins = gen_pc + INS_OFS;
            exp_q.push_back(e);
            gen_pc = gen_pc + PC_STEP;
        end
    endtask

    // Drive this cycle's inputs; memory answers after req has settled
    task automatic drive(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        rst               = r;
        bus.ready_i       = rdy && !r;
        bus.redirect_i    = rd && !r;
        bus.redirect_pc_i = rpc;
        #1;
        if (r || !bus.imem_req_o) begin
            bus.imem_ack_i   = 1'b0;
            bus.imem_rdata_i = $urandom;
            mem_cnt          = 0;
        end else if (mem_cnt >= mem_wait) begin
            bus.imem_ack_i   = 1'b1;
            bus.imem_rdata_i = bus.imem_addr_o + INS_OFS;
            mem_cnt          = 0;
            if (rand_wait) mem_wait = $urandom_range(0, 3);
        end else begin
            bus.imem_ack_i   = 1'b0;
            bus.imem_rdata_i = $urandom;
            mem_cnt++;
        end
        last_rst = r;
        last_red = rd && !r;
        last_rpc = rpc;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int k = 0; k < n; k++) begin
            sync_edge();
            drive(1'b0, rdy, 1'b0, 32'd0);
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            sync_edge();
            drive(1'b1, 1'b0, 1'b0, 32'd0);
        end
    endtask

    // Monitor: scoreboard pop on transfer plus memory-protocol rules
    logic        p_rst  = 1'b0;
    logic        p_req  = 1'b0;
    logic        p_ack  = 1'b0;
    logic [31:0] p_addr = 32'd0;
    logic        drain  = 1'b0;
    logic        want_v = 1'b0;
    logic [31:0] want   = 32'd0;

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (p_rst) begin
            check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
            check("rst_pc", bus.PC_o, 32'd0);
            check("rst_ins", bus.Ins_o, 32'd0);
        end
        if (rst) check("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
        if (bus.imem_ack_i && !bus.imem_req_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_without_req: ack=1 req=0 (t=%0t)", $time);
        end
        if (!rst && !p_rst && p_req && !p_ack) begin
            check("req_hold", {31'd0, bus.imem_req_o}, 32'd1);
            check("addr_hold", bus.imem_addr_o, p_addr);
        end
        if (!rst && want_v && !drain) begin
            check("new_req", {31'd0, bus.imem_req_o}, 32'd1);
            check("new_addr", bus.imem_addr_o, want);
            want_v = 1'b0;
        end
        if (bus.valid_o && bus.ready_i) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL xfer_unexpected: got pc %h, expected no transfer", bus.PC_o);
            end else begin
                e = exp_q.pop_front();
                check("xfer_pc", bus.PC_o, e.pc);
                check("xfer_ins", bus.Ins_o, e.ins);
            end
        end
        if (rst) begin
            drain  = 1'b0;
            want_v = 1'b1;
            want   = RESET_PC;
        end else if (bus.redirect_i) begin
            want_v = 1'b1;
            want   = bus.redirect_pc_i;
            drain  = bus.imem_req_o && !bus.imem_ack_i;
        end else if (drain && bus.imem_ack_i) begin
            drain = 1'b0;
        end
        p_rst  = rst;
        p_req  = bus.imem_req_o;
        p_ack  = bus.imem_ack_i;
        p_addr = bus.imem_addr_o;
    end

    initial begin
        int          cnt;
        logic        rd;
        logic        done;
        int          phase;
        logic [31:0] held;
        logic [31:0] rpc;

        rst               = 1'b1;
        bus.ready_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'd0;
        bus.imem_ack_i    = 1'b0;
        bus.imem_rdata_i  = 32'd0;

        // Zero-wait memory, always ready: one instruction per cycle from cycle 2
        mem_wait = 0;
        do_reset(3);
        sync_edge();
        check("c1_valid", {31'd0, bus.valid_o}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        sync_edge();
        check("c2_valid", {31'd0, bus.valid_o}, 32'd1);
        check("c2_pc", bus.PC_o, RESET_PC);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            sync_edge();
            if (bus.valid_o) cnt++;
            drive(1'b0, 1'b1, 1'b0, 32'd0);
        end
        check("throughput", cnt, 10);

        // Back-pressure: buffer fills, request drops, head holds
        sync_edge();
        held = bus.PC_o;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        run(4, 1'b0);
        sync_edge();
        check("full_req", {31'd0, bus.imem_req_o}, 32'd0);
        check("full_valid", {31'd0, bus.valid_o}, 32'd1);
        check("full_pc_hold", bus.PC_o, held);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        run(10, 1'b1);

        // 3 wait states, redirect to 0x40 in wait cycle 1
        do_reset(2);
        mem_wait = 3;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            sync_edge();
            rd = bus.imem_req_o && (mem_cnt == 1);
            drive(1'b0, 1'b1, rd, 32'h40);
            done = rd;
        end
        check("redir40_issued", {31'd0, done}, 32'd1);
        run(25, 1'b1);

        // Redirect to 0x80 in the same cycle addr 5 is acked
        mem_wait = 0;
        do_reset(2);
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            sync_edge();
            rd = bus.imem_req_o && (bus.imem_addr_o == 32'd5);
            drive(1'b0, 1'b1, rd, 32'h80);
            done = rd;
        end
        check("redir80_issued", {31'd0, done}, 32'd1);
        run(10, 1'b1);

        // Two redirects (0x10 then 0x20) inside one drain
        mem_wait = 3;
        phase = 0;
        for (int k = 0; k < 30 && phase < 2; k++) begin
            sync_edge();
            if (phase == 0 && bus.imem_req_o && mem_cnt == 0) begin
                drive(1'b0, 1'b1, 1'b1, 32'h10);
                phase = 1;
            end else if (phase == 1) begin
                drive(1'b0, 1'b1, 1'b1, 32'h20);
                phase = 2;
            end else begin
                drive(1'b0, 1'b1, 1'b0, 32'd0);
            end
        end
        check("double_redir", phase, 2);
        run(25, 1'b1);

        // PC wrap past 0xFFFFFFFF, then reset mid-stream
        mem_wait = 0;
        sync_edge();
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        run(8, 1'b1);
        do_reset(1);
        sync_edge();
        check("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        run(10, 1'b1);

        // Randomized traffic: wait states, back-pressure, redirects, resets
        rand_wait = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            sync_edge();
            case ($urandom_range(0, 3))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFFC + $urandom_range(0, 3);
                default: rpc = $urandom_range(0, 255);
            endcase
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 24) == 0), rpc);
        end
        rand_wait = 1'b0;
        mem_wait  = 0;
        run(10, 1'b1);

        check("activity", {31'd0, (n_xfer > 500)}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
